tanh_pwl_stream: RTL
====================

// Module: tanh_pwl_stream
// PURPOSE
// - Streaming, pipelined, parametrised tanh activation: LANES signed samples per beat, valid/ready handshake.
// - Shift-add piecewise-linear approximation (4 segments plus saturation), odd symmetry, no multipliers.
// - Generalises the fixed 4-bit combinational tanh cells to any width and lane count, with backpressure.
// - Sits between a MAC array output and the next layer's input buffer.
// PARAMETERS
// - WIDTH  8  sample width, in and out (>=6). Input Q3.(WIDTH-3) signed, range [-4,4). Output Q1.(WIDTH-1) signed.
// - LANES  1  parallel samples per beat. All lanes share one handshake.
// PORTS
// - clk        in   1             rising-edge clock
// - rst_n      in   1             asynchronous active-low reset
// - in_valid   in   1             input beat valid
// - in_ready   out  1             block can accept a beat this cycle
// - in_data    in   WIDTH*LANES   lane k at bits [k*WIDTH +: WIDTH]
// - out_valid  out  1             output beat valid
// - out_ready  in   1             downstream accepts this cycle
// - out_data   out  WIDTH*LANES   results, same lane packing
// - sat_cnt    out  16            present only with TANH_PWL_SATCNT_EN
// BEHAVIOUR
// - Reset (async assert, sync release): all stage valids=0, out_valid=0, out_data=0, sat_cnt=0.
// - Transfer occurs on a cycle with valid&&ready. Pipeline: S0 abs/sign/segment, S1 shift-add, S2 sign restore and saturate.
// - Latency: 3 cycles from input acceptance to out_valid when unstalled. Throughput: 1 beat/cycle.
// - Stage i loads when it is empty or its content moves on this cycle (bubbles collapse).
//   in_ready = !v0 || S0 advances. out_valid = v2. out_data holds stable while out_valid && !out_ready.
// - Per lane, a = |x| (WIDTH bits unsigned, so -4.0 gives 4.0). F = WIDTH-3 fractional bits; all terms truncate (floor).
//   a < 0.5: y=a | a < 1.0: y=a/2+0.25 | a < 1.5: y=a/4+0.5 | a < 2.25: y=a/8+0.6875 | a >= 2.25: saturate.
// - Result is scaled to output format (<<2), then clamped to MAXP = 2^(WIDTH-1)-1. The saturation region gives MAXP.
// - x < 0: out = -y. The most negative output is -MAXP; -2^(WIDTH-1) is never produced.
// - Segment edges belong to the upper segment (a=0.5 uses a/2+0.25). The PWL is continuous, so both give 0.5.
// - Reset mid-operation flushes all in-flight beats. No partial beat is emitted after reset release.
// - in_valid=0 with out_ready=1 drains the pipeline. Beats are never duplicated or dropped.
// CONFIGURATION
// - TANH_PWL_SATCNT_EN defined: sat_cnt port exists.
//   - It adds the number of lanes with a >= 2.25 in each beat accepted at the input.
//   - Saturating add; it sticks at 16'hFFFF and clears only on reset.
// - Not defined: no sat_cnt port and no counter logic. Datapath and timing are identical.
// TESTING (WIDTH=8, LANES=1 unless stated)
// - in 8'h08 (0.25) -> out 8'h20, 3 cycles after acceptance. in 8'h18 (0.75) -> 8'h50. in 8'h20 (1.0) -> 8'h60.
// - in 8'hE0 (-1.0) -> 8'hA0. in 8'h60 (3.0) -> 8'h7F. in 8'h80 (-4.0) -> 8'h81. in 8'h00 -> 8'h00.
// - Stream 8 beats with out_ready low for cycles 4-9:
//   - in_ready drops after 3 beats are buffered.
//   - out_data is stable while stalled.
//   - All 8 results arrive in order, with no loss or duplication.
// - LANES=4, in_data {8'h60,8'hE0,8'h18,8'h08}: out {8'h7F,8'hA0,8'h50,8'h20} in one beat.
//   With the macro on, sat_cnt increments by 1.
// - Assert rst_n low with 2 beats in flight: out_valid drops immediately. After release, no stale output appears.
//   The next input returns a correct result after 3 cycles.
// - Macro on, 70000 beats of 8'h7F (saturation region): sat_cnt stops at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/tanh_pwl_stream.sv
// -----------------------------------------------------------------------------
// tanh_pwl_stream
//
// Streaming tanh activation built from a shift-add piecewise-linear curve
// (four linear segments plus saturation), odd-symmetric, with no multipliers.
// LANES signed samples travel together as one beat under a single
// valid/ready handshake, through a three-stage pipeline:
//   S0: magnitude, sign and segment select
//   S1: shift-add evaluation of the selected segment
//   S2: scale to output format, clamp, sign restore (this is out_data)
//
// Number formats (F = WIDTH-3):
//   input  Q3.F signed, range [-4, 4)
//   output Q1.(WIDTH-1) signed, range [-MAXP, MAXP], MAXP = 2^(WIDTH-1)-1
//
// Parameters:
//   WIDTH  sample width in and out (>= 6)
//   LANES  samples per beat
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, flushes every in-flight beat
//   in_valid   input beat valid
//   in_ready   a beat can be accepted this cycle
//   in_data    lane k at bits [k*WIDTH +: WIDTH]
//   out_valid  output beat valid
//   out_ready  downstream accepts this cycle
//   out_data   results, same lane packing; held while out_valid && !out_ready
//   sat_cnt    saturating count of input lanes with |x| >= 2.25
//              (exists only when TANH_PWL_SATCNT_EN is defined)
//
// Optional feature macro: TANH_PWL_SATCNT_EN
//
// Handshake: a transfer happens on any cycle where valid && ready are both
// high. A stage loads when it is empty or when its current content moves on
// in the same cycle, so bubbles collapse and the pipe sustains 1 beat/cycle.
// Latency is 3 cycles from input acceptance to out_valid.
// -----------------------------------------------------------------------------
module tanh_pwl_stream #(
  parameter int WIDTH = 8,
  parameter int LANES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*LANES-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*LANES-1:0] out_data
`ifdef TANH_PWL_SATCNT_EN
  ,
  output logic [15:0]            sat_cnt
`endif
);

  localparam int F = WIDTH - 3;

  // Segment edges expressed in input LSBs (Q3.F).
  localparam logic [WIDTH-1:0] EDGE_0P5  = WIDTH'(1 << (F - 1));
  localparam logic [WIDTH-1:0] EDGE_1P0  = WIDTH'(1 << F);
  localparam logic [WIDTH-1:0] EDGE_1P5  = WIDTH'(3 << (F - 1));
  localparam logic [WIDTH-1:0] EDGE_2P25 = WIDTH'(9 << (F - 2));

  // Segment offsets in input LSBs; 0.6875 is floored when F < 4.
  localparam logic [WIDTH-1:0] OFS_HALF   = WIDTH'(1 << (F - 2));
  localparam logic [WIDTH-1:0] OFS_QTR    = WIDTH'(1 << (F - 1));
  localparam logic [WIDTH-1:0] OFS_EIGHTH = WIDTH'((11 << F) >> 4);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Largest positive output, widened to compare against the <<2 result.
  localparam logic [WIDTH+1:0] MAXP_EXT = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAXP     = MAXP_EXT[WIDTH-1:0];

  typedef enum logic [2:0] {
    SEG_LIN    = 3'd0,  // a < 0.5      : y = a
    SEG_HALF   = 3'd1,  // a < 1.0      : y = a/2 + 0.25
    SEG_QTR    = 3'd2,  // a < 1.5      : y = a/4 + 0.5
    SEG_EIGHTH = 3'd3,  // a < 2.25     : y = a/8 + 0.6875
    SEG_SAT    = 3'd4   // a >= 2.25    : y = MAXP
  } seg_e;

  // ---------------------------------------------------------------------------
  // Stage advance network. advN is high when stage N may load this cycle.
  // ---------------------------------------------------------------------------
  logic v0, v1, v2;
  logic adv0, adv1, adv2;

  assign adv2      = !v2 || out_ready;
  assign adv1      = !v1 || adv2;
  assign adv0      = !v0 || adv1;
  assign in_ready  = adv0;
  assign out_valid = v2;

  // ---------------------------------------------------------------------------
  // S0 combinational: magnitude, sign, segment.
  // |x| is kept WIDTH bits unsigned so that -4.0 maps to +4.0 (MSB set).
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] c0_abs [LANES];
  seg_e             c0_seg [LANES];
  logic [LANES-1:0] c0_neg;

  always_comb begin
    c0_neg = '0;
    for (int k = 0; k < LANES; k++) begin
      c0_neg[k] = in_data[k*WIDTH + WIDTH - 1];
      if (c0_neg[k]) begin
        c0_abs[k] = (~in_data[k*WIDTH +: WIDTH]) + ONE;
      end else begin
        c0_abs[k] = in_data[k*WIDTH +: WIDTH];
      end

      // Edges belong to the upper segment.
      if (c0_abs[k] < EDGE_0P5) begin
        c0_seg[k] = SEG_LIN;
      end else if (c0_abs[k] < EDGE_1P0) begin
        c0_seg[k] = SEG_HALF;
      end else if (c0_abs[k] < EDGE_1P5) begin
        c0_seg[k] = SEG_QTR;
      end else if (c0_abs[k] < EDGE_2P25) begin
        c0_seg[k] = SEG_EIGHTH;
      end else begin
        c0_seg[k] = SEG_SAT;
      end
    end
  end

  logic [WIDTH-1:0] s0_abs [LANES];
  seg_e             s0_seg [LANES];
  logic [LANES-1:0] s0_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0     <= 1'b0;
      s0_neg <= '0;
      for (int k = 0; k < LANES; k++) begin
        s0_abs[k] <= '0;
        s0_seg[k] <= SEG_LIN;
      end
    end else if (adv0) begin
      v0 <= in_valid;
      if (in_valid) begin
        s0_neg <= c0_neg;
        for (int k = 0; k < LANES; k++) begin
          s0_abs[k] <= c0_abs[k];
          s0_seg[k] <= c0_seg[k];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S1 combinational: shift-add. Right shifts truncate toward zero, which is
  // floor because the operand is a magnitude.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] c1_y [LANES];
  logic [LANES-1:0] c1_sat;

  always_comb begin
    c1_sat = '0;
    for (int k = 0; k < LANES; k++) begin
      c1_y[k] = '0;
      unique case (s0_seg[k])
        SEG_LIN:    c1_y[k] = s0_abs[k];
        SEG_HALF:   c1_y[k] = (s0_abs[k] >> 1) + OFS_HALF;
        SEG_QTR:    c1_y[k] = (s0_abs[k] >> 2) + OFS_QTR;
        SEG_EIGHTH: c1_y[k] = (s0_abs[k] >> 3) + OFS_EIGHTH;
        SEG_SAT:    c1_sat[k] = 1'b1;
        default:    c1_y[k] = '0;
      endcase
    end
  end

  logic [WIDTH-1:0] s1_y [LANES];
  logic [LANES-1:0] s1_sat;
  logic [LANES-1:0] s1_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      s1_sat <= '0;
      s1_neg <= '0;
      for (int k = 0; k < LANES; k++) begin
        s1_y[k] <= '0;
      end
    end else if (adv1) begin
      v1 <= v0;
      if (v0) begin
        s1_sat <= c1_sat;
        s1_neg <= s0_neg;
        for (int k = 0; k < LANES; k++) begin
          s1_y[k] <= c1_y[k];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2 combinational: Q3.F -> Q1.(WIDTH-1) is a left shift by 2, then clamp
  // to MAXP. Negation of a value in [0, MAXP] can never reach -2^(WIDTH-1).
  // ---------------------------------------------------------------------------
  logic [WIDTH+1:0]       c2_scaled [LANES];
  logic [WIDTH-1:0]       c2_mag    [LANES];
  logic [WIDTH*LANES-1:0] c2_res;

  always_comb begin
    c2_res = '0;
    for (int k = 0; k < LANES; k++) begin
      c2_scaled[k] = {s1_y[k], 2'b00};
      if (s1_sat[k] || (c2_scaled[k] > MAXP_EXT)) begin
        c2_mag[k] = MAXP;
      end else begin
        c2_mag[k] = c2_scaled[k][WIDTH-1:0];
      end
      if (s1_neg[k]) begin
        c2_res[k*WIDTH +: WIDTH] = (~c2_mag[k]) + ONE;
      end else begin
        c2_res[k*WIDTH +: WIDTH] = c2_mag[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2       <= 1'b0;
      out_data <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        out_data <= c2_res;
      end
    end
  end

`ifdef TANH_PWL_SATCNT_EN
  // ---------------------------------------------------------------------------
  // Saturation counter: counts saturating lanes of each accepted input beat.
  // One extra sum bit detects overflow; the counter then sticks at all-ones.
  // ---------------------------------------------------------------------------
  logic [16:0] sat_sum;

  always_comb begin
    sat_sum = {1'b0, sat_cnt};
    for (int k = 0; k < LANES; k++) begin
      if (c0_seg[k] == SEG_SAT) begin
        sat_sum = sat_sum + 17'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (in_valid && in_ready) begin
      sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end
`endif

endmodule
